// File: rtl/video_mixer_pkg.sv
// Shared constants and types for the video output mixer pipeline.
// Colour-space constants are integer coefficients scaled by 256, offsets/clamps in 8-bit units.
package video_mixer_pkg;

  localparam int LAT = 3;

  localparam int KY_R  = 66;
  localparam int KY_G  = 129;
  localparam int KY_B  = 25;
  localparam int KPB_R = -38;
  localparam int KPB_G = -74;
  localparam int KPB_B = 112;
  localparam int KPR_R = 112;
  localparam int KPR_G = -94;
  localparam int KPR_B = -18;

  localparam int K_FULL_Y = 149;
  localparam int K_FULL_C = 146;

  localparam int Y_OFS8 = 16;
  localparam int C_OFS8 = 128;
  localparam int Y_MIN8 = 16;
  localparam int Y_MAX8 = 235;
  localparam int C_MIN8 = 16;
  localparam int C_MAX8 = 240;

  typedef enum logic [1:0] {
    SL_NONE = 2'd0,
    SL_25   = 2'd1,
    SL_50   = 2'd2,
    SL_75   = 2'd3
  } scanline_e;

  // 2x2 Bayer matrix indexed by {row, col}
  localparam logic [1:0] BAYER [4] = '{2'd0, 2'd2, 2'd3, 2'd1};

endpackage

// File: rtl/video_mixer_pipe_if.sv
// Pixel/control input bus and VGA output bus of the video mixer pipeline.
// master = pixel source (drives colour, syncs, modes); slave = the mixer.
interface video_mixer_pipe_if #(
  parameter int IN_DW  = 8,
  parameter int OUT_DW = 6
);
  logic              pix_ce;
  logic [IN_DW-1:0]  R;
  logic [IN_DW-1:0]  G;
  logic [IN_DW-1:0]  B;
  logic              HSync;
  logic              VSync;
  logic [1:0]        scanlines;
  logic              ypbpr;
  logic              ypbpr_full;
  logic              csync;
  logic [OUT_DW-1:0] VGA_R;
  logic [OUT_DW-1:0] VGA_G;
  logic [OUT_DW-1:0] VGA_B;
  logic              VGA_HS;
  logic              VGA_VS;

  modport master (
    output pix_ce, R, G, B, HSync, VSync, scanlines, ypbpr, ypbpr_full, csync,
    input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS
  );

  modport slave (
    input  pix_ce, R, G, B, HSync, VSync, scanlines, ypbpr, ypbpr_full, csync,
    output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS
  );
endinterface

// File: rtl/video_mixer_pipe_ypbpr_conv.sv
// RGB to YPbPr arithmetic: coefficient products (stage 2 register), then offset,
// clamp and optional full-range expansion (stage 3, combinational into the caller's output register).
module ypbpr_conv
  import video_mixer_pkg::*;
#(
  parameter int IN_DW = 8
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic [IN_DW-1:0] i_r,
  input  logic [IN_DW-1:0] i_g,
  input  logic [IN_DW-1:0] i_b,
  input  logic             i_full,
  output logic [IN_DW-1:0] o_y,
  output logic [IN_DW-1:0] o_pb,
  output logic [IN_DW-1:0] o_pr
);

  localparam int AW = IN_DW + 11;
  localparam int S  = 1 << (IN_DW - 8);

  localparam logic signed [AW-1:0] CY_R  = AW'(KY_R);
  localparam logic signed [AW-1:0] CY_G  = AW'(KY_G);
  localparam logic signed [AW-1:0] CY_B  = AW'(KY_B);
  localparam logic signed [AW-1:0] CPB_R = AW'(KPB_R);
  localparam logic signed [AW-1:0] CPB_G = AW'(KPB_G);
  localparam logic signed [AW-1:0] CPB_B = AW'(KPB_B);
  localparam logic signed [AW-1:0] CPR_R = AW'(KPR_R);
  localparam logic signed [AW-1:0] CPR_G = AW'(KPR_G);
  localparam logic signed [AW-1:0] CPR_B = AW'(KPR_B);

  localparam logic signed [AW-1:0] Y_OFS = AW'(Y_OFS8 * S * 256);
  localparam logic signed [AW-1:0] C_OFS = AW'(C_OFS8 * S * 256);
  localparam logic signed [AW-1:0] Y_LO  = AW'(Y_MIN8 * S);
  localparam logic signed [AW-1:0] Y_HI  = AW'(Y_MAX8 * S);
  localparam logic signed [AW-1:0] C_LO  = AW'(C_MIN8 * S);
  localparam logic signed [AW-1:0] C_HI  = AW'(C_MAX8 * S);
  localparam logic [IN_DW-1:0]     Y_LO_U = IN_DW'(Y_MIN8 * S);
  localparam logic [IN_DW-1:0]     C_LO_U = IN_DW'(C_MIN8 * S);

  function automatic logic [IN_DW-1:0] clamp_rng(
    input logic signed [AW-1:0] v,
    input logic signed [AW-1:0] lo,
    input logic signed [AW-1:0] hi
  );
    if (v < lo) return lo[IN_DW-1:0];
    if (v > hi) return hi[IN_DW-1:0];
    return v[IN_DW-1:0];
  endfunction

  // Input is already clamped to >= lo, so the subtraction never wraps
  function automatic logic [IN_DW-1:0] expand_sat(
    input logic [IN_DW-1:0] v,
    input logic [IN_DW-1:0] lo,
    input logic [7:0]       k
  );
    logic [IN_DW-1:0] d;
    logic [IN_DW+7:0] p;
    d = v - lo;
    p = {8'd0, d} * {{IN_DW{1'b0}}, k};
    p = p >> 7;
    if (p > {8'd0, {IN_DW{1'b1}}}) return {IN_DW{1'b1}};
    return p[IN_DW-1:0];
  endfunction

  logic signed [AW-1:0] w_rs, w_gs, w_bs;
  logic signed [AW-1:0] w_y, w_pb, w_pr;

  assign w_rs = $signed({{(AW-IN_DW){1'b0}}, i_r});
  assign w_gs = $signed({{(AW-IN_DW){1'b0}}, i_g});
  assign w_bs = $signed({{(AW-IN_DW){1'b0}}, i_b});

  assign w_y  = CY_R  * w_rs + CY_G  * w_gs + CY_B  * w_bs;
  assign w_pb = CPB_R * w_rs + CPB_G * w_gs + CPB_B * w_bs;
  assign w_pr = CPR_R * w_rs + CPR_G * w_gs + CPR_B * w_bs;

  // ---- stage 2 register: products ----
  logic signed [AW-1:0] r_y_p2, r_pb_p2, r_pr_p2;
  logic                 r_full_p2;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_y_p2    <= '0;
      r_pb_p2   <= '0;
      r_pr_p2   <= '0;
      r_full_p2 <= 1'b0;
    end else begin
      r_y_p2    <= w_y;
      r_pb_p2   <= w_pb;
      r_pr_p2   <= w_pr;
      r_full_p2 <= i_full;
    end
  end

  // ---- stage 3 combinational: offset, scale down, clamp, expand ----
  logic signed [AW-1:0] w_y_sh, w_pb_sh, w_pr_sh;
  logic [IN_DW-1:0]     w_y_lim, w_pb_lim, w_pr_lim;

  assign w_y_sh  = (r_y_p2  + Y_OFS) >>> 8;
  assign w_pb_sh = (r_pb_p2 + C_OFS) >>> 8;
  assign w_pr_sh = (r_pr_p2 + C_OFS) >>> 8;

  assign w_y_lim  = clamp_rng(w_y_sh,  Y_LO, Y_HI);
  assign w_pb_lim = clamp_rng(w_pb_sh, C_LO, C_HI);
  assign w_pr_lim = clamp_rng(w_pr_sh, C_LO, C_HI);

  assign o_y  = r_full_p2 ? expand_sat(w_y_lim,  Y_LO_U, 8'(K_FULL_Y)) : w_y_lim;
  assign o_pb = r_full_p2 ? expand_sat(w_pb_lim, C_LO_U, 8'(K_FULL_C)) : w_pb_lim;
  assign o_pr = r_full_p2 ? expand_sat(w_pr_lim, C_LO_U, 8'(K_FULL_C)) : w_pr_lim;

endmodule

// File: rtl/video_mixer_pipe.sv
// Fixed-latency VGA output mixer: scanline dimming, optional YPbPr, width reduction, sync polarity.
// Define VIDEO_MIXER_DITHER_EN to add a 2x2 ordered dither ahead of the width reduction.
module video_mixer_pipe
  import video_mixer_pkg::*;
#(
  parameter int IN_DW  = 8,
  parameter int OUT_DW = 6
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  video_mixer_pipe_if.slave vif
);

  localparam int DROP = IN_DW - OUT_DW;

  function automatic logic [IN_DW-1:0] dim(
    input logic [IN_DW-1:0] x,
    input scanline_e        lvl,
    input logic             on
  );
    if (!on) return x;
    case (lvl)
      SL_25:   return (x >> 1) + (x >> 2);
      SL_50:   return x >> 1;
      SL_75:   return x >> 2;
      default: return x;
    endcase
  endfunction

  function automatic logic [OUT_DW-1:0] reduce(input logic [IN_DW-1:0] x);
    return OUT_DW'(x >> DROP);
  endfunction

  // ---- stage 1: input capture and line-phase tracking ----
  logic [IN_DW-1:0] r_r_p1, r_g_p1, r_b_p1;
  logic             r_hs_p1, r_vs_p1;
  scanline_e        r_sl_p1;
  logic             r_ypbpr_p1, r_full_p1, r_csync_p1;
  logic             r_phase;
  logic             w_hs_fall, w_vs_fall;

  assign w_hs_fall = r_hs_p1 & ~vif.HSync;
  assign w_vs_fall = r_vs_p1 & ~vif.VSync;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_r_p1     <= '0;
      r_g_p1     <= '0;
      r_b_p1     <= '0;
      r_hs_p1    <= 1'b0;
      r_vs_p1    <= 1'b0;
      r_sl_p1    <= SL_NONE;
      r_ypbpr_p1 <= 1'b0;
      r_full_p1  <= 1'b0;
      r_csync_p1 <= 1'b0;
      r_phase    <= 1'b0;
    end else begin
      r_r_p1     <= vif.R;
      r_g_p1     <= vif.G;
      r_b_p1     <= vif.B;
      r_hs_p1    <= vif.HSync;
      r_vs_p1    <= vif.VSync;
      r_sl_p1    <= scanline_e'(vif.scanlines);
      r_ypbpr_p1 <= vif.ypbpr;
      r_full_p1  <= vif.ypbpr_full;
      r_csync_p1 <= vif.csync;
      if (w_vs_fall)      r_phase <= 1'b0;
      else if (w_hs_fall) r_phase <= ~r_phase;
    end
  end

`ifdef VIDEO_MIXER_DITHER_EN
  localparam int TH_SHL = (DROP >= 2) ? DROP - 2 : 0;
  localparam int TH_SHR = (DROP >= 2) ? 0 : 2 - DROP;

  function automatic logic [IN_DW-1:0] sat_add(input logic [IN_DW-1:0] x, input logic [IN_DW-1:0] t);
    logic [IN_DW:0] s;
    s = {1'b0, x} + {1'b0, t};
    return s[IN_DW] ? {IN_DW{1'b1}} : s[IN_DW-1:0];
  endfunction

  logic r_col;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)       r_col <= 1'b0;
    else if (w_hs_fall) r_col <= 1'b0;
    else if (vif.pix_ce) r_col <= ~r_col;
  end
`else
  logic w_unused_pix_ce;
  assign w_unused_pix_ce = vif.pix_ce;
`endif

  // ---- stage 2: dimming and colour-space products ----
  logic [IN_DW-1:0] w_r_dim, w_g_dim, w_b_dim;
  logic [IN_DW-1:0] w_y, w_pb, w_pr;

  assign w_r_dim = dim(r_r_p1, r_sl_p1, r_phase);
  assign w_g_dim = dim(r_g_p1, r_sl_p1, r_phase);
  assign w_b_dim = dim(r_b_p1, r_sl_p1, r_phase);

  ypbpr_conv #(.IN_DW(IN_DW)) u_conv (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .i_r     (w_r_dim),
    .i_g     (w_g_dim),
    .i_b     (w_b_dim),
    .i_full  (r_full_p1),
    .o_y     (w_y),
    .o_pb    (w_pb),
    .o_pr    (w_pr)
  );

  logic [IN_DW-1:0] r_r_p2, r_g_p2, r_b_p2;
  logic             r_hs_p2, r_vs_p2, r_ypbpr_p2, r_csync_p2;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_r_p2     <= '0;
      r_g_p2     <= '0;
      r_b_p2     <= '0;
      r_hs_p2    <= 1'b0;
      r_vs_p2    <= 1'b0;
      r_ypbpr_p2 <= 1'b0;
      r_csync_p2 <= 1'b0;
    end else begin
      r_r_p2     <= w_r_dim;
      r_g_p2     <= w_g_dim;
      r_b_p2     <= w_b_dim;
      r_hs_p2    <= r_hs_p1;
      r_vs_p2    <= r_vs_p1;
      r_ypbpr_p2 <= r_ypbpr_p1;
      r_csync_p2 <= r_csync_p1;
    end
  end

`ifdef VIDEO_MIXER_DITHER_EN
  logic r_row_p2, r_col_p2;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_row_p2 <= 1'b0;
      r_col_p2 <= 1'b0;
    end else begin
      r_row_p2 <= r_phase;
      r_col_p2 <= r_col;
    end
  end
`endif

  // ---- stage 3: output select, optional dither, width reduction, sync polarity ----
  logic [IN_DW-1:0] w_sel_r, w_sel_g, w_sel_b;
  logic [IN_DW-1:0] w_fin_r, w_fin_g, w_fin_b;

  assign w_sel_r = r_ypbpr_p2 ? w_pr : r_r_p2;
  assign w_sel_g = r_ypbpr_p2 ? w_y  : r_g_p2;
  assign w_sel_b = r_ypbpr_p2 ? w_pb : r_b_p2;

`ifdef VIDEO_MIXER_DITHER_EN
  logic [IN_DW-1:0] w_thr;
  assign w_thr   = (IN_DW'(BAYER[{r_row_p2, r_col_p2}]) << TH_SHL) >> TH_SHR;
  assign w_fin_r = sat_add(w_sel_r, w_thr);
  assign w_fin_g = sat_add(w_sel_g, w_thr);
  assign w_fin_b = sat_add(w_sel_b, w_thr);
`else
  assign w_fin_r = w_sel_r;
  assign w_fin_g = w_sel_g;
  assign w_fin_b = w_sel_b;
`endif

  logic [OUT_DW-1:0] r_vga_r_p3, r_vga_g_p3, r_vga_b_p3;
  logic              r_vga_hs_p3, r_vga_vs_p3;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_vga_r_p3  <= '0;
      r_vga_g_p3  <= '0;
      r_vga_b_p3  <= '0;
      r_vga_hs_p3 <= 1'b1;
      r_vga_vs_p3 <= 1'b1;
    end else begin
      r_vga_r_p3 <= reduce(w_fin_r);
      r_vga_g_p3 <= reduce(w_fin_g);
      r_vga_b_p3 <= reduce(w_fin_b);
      if (r_ypbpr_p2 | r_csync_p2) begin
        r_vga_hs_p3 <= ~(r_hs_p2 ^ r_vs_p2);
        r_vga_vs_p3 <= 1'b1;
      end else begin
        r_vga_hs_p3 <= ~r_hs_p2;
        r_vga_vs_p3 <= ~r_vs_p2;
      end
    end
  end

  assign vif.VGA_R  = r_vga_r_p3;
  assign vif.VGA_G  = r_vga_g_p3;
  assign vif.VGA_B  = r_vga_b_p3;
  assign vif.VGA_HS = r_vga_hs_p3;
  assign vif.VGA_VS = r_vga_vs_p3;

endmodule

// File: tb/tb_video_mixer_pipe.sv
// Scoreboard bench for video_mixer_pipe: directed spec vectors plus a randomized stream
// checked against an arithmetic reference model; a monitor pops expectations as outputs become due.
module tb_video_mixer_pipe;
  import video_mixer_pkg::*;

  localparam int IN_DW  = 8;
  localparam int OUT_DW = 6;
  localparam int S      = 1 << (IN_DW - 8);
  localparam int MAXV   = (1 << IN_DW) - 1;
  localparam int SH     = IN_DW - OUT_DW;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk_sys = ~clk_sys;

  video_mixer_pipe_if #(.IN_DW(IN_DW), .OUT_DW(OUT_DW)) vif();

  video_mixer_pipe #(.IN_DW(IN_DW), .OUT_DW(OUT_DW)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .vif     (vif)
  );

  typedef struct {
    int due;
    int id;
    int r, g, b;
    bit hs, vs;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;
  int id_cnt = 0;

  always @(posedge clk_sys) edge_cnt <= edge_cnt + 1;

  // reference model state: previous sync levels, line parity, dither column
  bit m_phs, m_pvs, m_phase, m_col;

  function automatic int dimf(int x, int sl, bit ph);
    if (!ph || sl == 0) return x;
    if (sl == 1) return x / 2 + x / 4;
    if (sl == 2) return x / 2;
    return x / 4;
  endfunction

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic int fullr(int v, int k);
    int t;
    t = ((v - 16 * S) * k) >> 7;
    return (t > MAXV) ? MAXV : t;
  endfunction

  function automatic int dith(int v, bit row, bit col);
    int bay[4] = '{0, 2, 3, 1};
    int t;
    t = bay[row * 2 + col];
    t = (SH >= 2) ? (t << (SH - 2)) : (t >> (2 - SH));
    return (v + t > MAXV) ? MAXV : v + t;
  endfunction

  task automatic send(input int r, input int g, input int b, input bit hs, input bit vs,
                      input int sl, input bit yp, input bit full, input bit cs, input bit ce,
                      input bit has_k = 1'b0, input int kr = 0, input int kg = 0, input int kb = 0);
    exp_t e;
    bit hf, vf;
    int dr, dg, db, yv, pb, pr, o_r, o_g, o_b;
    @(negedge clk_sys);
    vif.R = IN_DW'(r); vif.G = IN_DW'(g); vif.B = IN_DW'(b);
    vif.HSync = hs; vif.VSync = vs; vif.scanlines = 2'(sl);
    vif.ypbpr = yp; vif.ypbpr_full = full; vif.csync = cs; vif.pix_ce = ce;

    hf = m_phs & ~hs;
    vf = m_pvs & ~vs;
    if (vf) m_phase = 1'b0;
    else if (hf) m_phase = ~m_phase;
    if (hf) m_col = 1'b0;
    else if (ce) m_col = ~m_col;
    m_phs = hs;
    m_pvs = vs;

    dr = dimf(r, sl, m_phase);
    dg = dimf(g, sl, m_phase);
    db = dimf(b, sl, m_phase);
    yv = clampi((66 * dr + 129 * dg + 25 * db + 16 * S * 256) >>> 8, 16 * S, 235 * S);
    pb = clampi((-38 * dr - 74 * dg + 112 * db + 128 * S * 256) >>> 8, 16 * S, 240 * S);
    pr = clampi((112 * dr - 94 * dg - 18 * db + 128 * S * 256) >>> 8, 16 * S, 240 * S);
    if (full) begin
      yv = fullr(yv, 149);
      pb = fullr(pb, 146);
      pr = fullr(pr, 146);
    end
    o_r = yp ? pr : dr;
    o_g = yp ? yv : dg;
    o_b = yp ? pb : db;
`ifdef VIDEO_MIXER_DITHER_EN
    o_r = dith(o_r, m_phase, m_col);
    o_g = dith(o_g, m_phase, m_col);
    o_b = dith(o_b, m_phase, m_col);
    has_k = 1'b0;
`endif
    e.r = o_r >> SH;
    e.g = o_g >> SH;
    e.b = o_b >> SH;
    if (has_k) begin
      e.r = kr; e.g = kg; e.b = kb;
    end
    if (yp || cs) begin
      e.hs = ~(hs ^ vs);
      e.vs = 1'b1;
    end else begin
      e.hs = ~hs;
      e.vs = ~vs;
    end
    e.due = edge_cnt + LAT;
    e.id  = id_cnt;
    id_cnt++;
    sbq.push_back(e);
  endtask

  task automatic check_reset(input string name);
    total++;
    if (vif.VGA_R !== '0 || vif.VGA_G !== '0 || vif.VGA_B !== '0 ||
        vif.VGA_HS !== 1'b1 || vif.VGA_VS !== 1'b1) begin
      bad++;
      $display("FAIL %s got rgb=%0d/%0d/%0d hs=%b vs=%b want rgb=0/0/0 hs=1 vs=1",
               name, vif.VGA_R, vif.VGA_G, vif.VGA_B, vif.VGA_HS, vif.VGA_VS);
    end
  endtask

  task automatic idle_inputs();
    vif.R = '0; vif.G = '0; vif.B = '0;
    vif.HSync = 1'b0; vif.VSync = 1'b0; vif.scanlines = 2'd0;
    vif.ypbpr = 1'b0; vif.ypbpr_full = 1'b0; vif.csync = 1'b0; vif.pix_ce = 1'b0;
  endtask

  // reset asserted and released mid-cycle, away from the clock edge
  task automatic do_reset(input string name);
    @(negedge clk_sys);
    #2 reset_n = 1'b0;
    #1 check_reset(name);
    sbq.delete();
    m_phs = 1'b0; m_pvs = 1'b0; m_phase = 1'b0; m_col = 1'b0;
    idle_inputs();
    @(negedge clk_sys);
    @(negedge clk_sys);
    #2 reset_n = 1'b1;
  endtask

  // monitor: compare every expectation whose output is due at this sampling point
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_sys);
      while (sbq.size() > 0 && sbq[0].due <= edge_cnt) begin
        e = sbq.pop_front();
        total++;
        if (int'(vif.VGA_R) != e.r || int'(vif.VGA_G) != e.g || int'(vif.VGA_B) != e.b ||
            vif.VGA_HS !== e.hs || vif.VGA_VS !== e.vs) begin
          bad++;
          $display("FAIL pix%0d got rgb=%0d/%0d/%0d hs=%b vs=%b want rgb=%0d/%0d/%0d hs=%b vs=%b",
                   e.id, vif.VGA_R, vif.VGA_G, vif.VGA_B, vif.VGA_HS, vif.VGA_VS,
                   e.r, e.g, e.b, e.hs, e.vs);
        end
      end
    end
  end

  initial begin
    int sl, r, g, b;
    bit yp, full, cs, hs, vs;
    idle_inputs();
    do_reset("reset_initial");

    // scanline 50% on 0xF0 across lines, then simultaneous VSync/HSync fall
    send(8'hF0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 1, 60, 0, 0);
    send(8'hF0, 0, 0, 1, 0, 2, 0, 0, 0, 1, 1, 60, 0, 0);
    send(8'hF0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 1, 30, 0, 0);
    send(8'hF0, 0, 0, 1, 1, 2, 0, 0, 0, 1, 1, 30, 0, 0);
    send(8'hF0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 1, 60, 0, 0);
    // RGB passthrough with an HSync pulse
    send(8'hFC, 8'h80, 8'h04, 1, 0, 0, 0, 0, 0, 1, 1, 63, 32, 1);
    send(8'hFC, 8'h80, 8'h04, 0, 0, 0, 0, 0, 0, 1, 1, 63, 32, 1);
    // limited-range YPbPr white and black
    send(8'hFF, 8'hFF, 8'hFF, 0, 0, 0, 1, 0, 0, 1, 1, 32, 58, 32);
    send(8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0, 0, 1, 1, 32, 4, 32);
    // full-range YPbPr white and black
    send(8'hFF, 8'hFF, 8'hFF, 0, 0, 0, 1, 1, 0, 1, 1, 31, 63, 31);
    send(8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 1, 0, 1, 1, 31, 0, 31);
    // composite sync combinations
    send(8'hFC, 8'h80, 8'h04, 1, 0, 0, 0, 0, 1, 1, 1, 63, 32, 1);
    send(8'hFC, 8'h80, 8'h04, 1, 1, 0, 0, 0, 1, 1, 1, 63, 32, 1);
    send(8'hFC, 8'h80, 8'h04, 0, 1, 0, 0, 0, 1, 1, 1, 63, 32, 1);
    send(8'hFC, 8'h80, 8'h04, 0, 0, 0, 0, 0, 1, 1, 1, 63, 32, 1);

    hs = 1'b0; vs = 1'b0; sl = 0; yp = 1'b0; full = 1'b0; cs = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (i % 8 == 0) begin
        sl   = $urandom_range(0, 3);
        yp   = 1'($urandom_range(0, 1));
        full = 1'($urandom_range(0, 1));
        cs   = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 4) == 0) hs = ~hs;
      if ($urandom_range(0, 8) == 0) vs = ~vs;
      r = $urandom_range(0, MAXV);
      g = $urandom_range(0, MAXV);
      b = $urandom_range(0, MAXV);
      if (i % 50 == 7) begin r = MAXV; g = MAXV; b = MAXV; end
      if (i % 50 == 8) begin r = 0; g = 0; b = 0; end
      send(r, g, b, hs, vs, sl, yp, full, cs, 1'($urandom_range(0, 1)));
      if (i == 1000) begin
        do_reset("reset_midstream");
        hs = 1'b0; vs = 1'b0;
      end
    end

    for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clk_sys);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
